// File: rtl/mipi_lane_hs_ctrl_if.sv
// Lane-side signal bundle for the HS-entry/exit sequencer.
// The pad/deserializer side drives through master; the sequencer uses slave.
interface mipi_lane_hs_ctrl_if;
  logic        enable;
  logic        mdp_lp;
  logic        mdn_lp;
  logic        sync_found;
  logic        lane_term_en;
  logic        hs_rx_en;
  logic        sync_search;
  logic        hs_active;
  logic        sot_pulse;
  logic        eot_pulse;
  logic        err_sot;
  logic        err_ctrl;
  logic        err_timeout;
  logic [1:0]  lp_state;
  logic [15:0] burst_count;

  modport master (
    output enable, mdp_lp, mdn_lp, sync_found,
    input  lane_term_en, hs_rx_en, sync_search, hs_active,
    input  sot_pulse, eot_pulse, err_sot, err_ctrl, err_timeout,
    input  lp_state, burst_count
  );

  modport slave (
    input  enable, mdp_lp, mdn_lp, sync_found,
    output lane_term_en, hs_rx_en, sync_search, hs_active,
    output sot_pulse, eot_pulse, err_sot, err_ctrl, err_timeout,
    output lp_state, burst_count
  );
endinterface

// File: rtl/mipi_lane_hs_ctrl.sv
// Per-lane D-PHY HS-entry/exit sequencer for the CSI-2 receive path.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_STOP    | LP-11 idle, all HS enables off
// ST_HS_RQST | LP-01 seen, waiting for LP-00 bridge state
// ST_SETTLE  | termination + HS receiver on, waiting T_SETTLE_CYC
// ST_SYNC    | hunting for the sync byte, bounded by SYNC_TIMEOUT_CYC
// ST_HS      | burst in progress, ends on LP-11 or HS_TIMEOUT_CYC
// ST_ERR     | protocol error, parked until the lane returns to LP-11
//
// Every output is registered and decoded from the next state, so the
// enables and the one-cycle event pulses all change on the transition edge.
module mipi_lane_hs_ctrl #(
  parameter int T_SETTLE_CYC     = 12,
  parameter int SYNC_TIMEOUT_CYC = 64,
  parameter int HS_TIMEOUT_CYC   = 65535
) (
  input  logic                 phy_clk,
  input  logic                 resetb,
  mipi_lane_hs_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_HS_RQST = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SYNC    = 3'd3,
    ST_HS      = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  localparam logic [1:0] LP_00 = 2'b00;
  localparam logic [1:0] LP_01 = 2'b01;
  localparam logic [1:0] LP_10 = 2'b10;
  localparam logic [1:0] LP_11 = 2'b11;

  // Last count value of each timed state; the transition fires when the
  // counter already holds this value, i.e. after exactly N cycles in state.
  localparam logic [15:0] SETTLE_LAST = 16'(T_SETTLE_CYC - 1);
  localparam logic [15:0] SYNC_LAST   = 16'(SYNC_TIMEOUT_CYC - 1);
  localparam logic [15:0] HS_LAST     = 16'(HS_TIMEOUT_CYC - 1);

  logic [1:0]  lp_s1_q;
  logic [1:0]  lp_s2_q;

  state_t      state_q;
  state_t      state_nxt;
  logic [15:0] cnt_q;
  logic [15:0] cnt_nxt;
  logic [15:0] burst_cnt_q;
  logic [15:0] burst_cnt_nxt;

  logic        sot_nxt;
  logic        eot_nxt;
  logic        err_sot_nxt;
  logic        err_ctrl_nxt;
  logic        err_to_nxt;

  logic        term_nxt;
  logic        rx_nxt;
  logic        search_nxt;
  logic        active_nxt;

  logic        term_q;
  logic        rx_q;
  logic        search_q;
  logic        active_q;
  logic        sot_q;
  logic        eot_q;
  logic        err_sot_q;
  logic        err_ctrl_q;
  logic        err_to_q;

  // Two-flop synchronizer on the asynchronous LP comparator outputs; idles at LP-11.
  always_ff @(posedge phy_clk) begin
    if (!resetb) begin
      lp_s1_q <= LP_11;
      lp_s2_q <= LP_11;
    end else begin
      lp_s1_q <= {bus.mdp_lp, bus.mdn_lp};
      lp_s2_q <= lp_s1_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge phy_clk) begin
    if (!resetb) begin
      state_q     <= ST_STOP;
      cnt_q       <= '0;
      burst_cnt_q <= '0;
      term_q      <= 1'b0;
      rx_q        <= 1'b0;
      search_q    <= 1'b0;
      active_q    <= 1'b0;
      sot_q       <= 1'b0;
      eot_q       <= 1'b0;
      err_sot_q   <= 1'b0;
      err_ctrl_q  <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      burst_cnt_q <= burst_cnt_nxt;
      term_q      <= term_nxt;
      rx_q        <= rx_nxt;
      search_q    <= search_nxt;
      active_q    <= active_nxt;
      sot_q       <= sot_nxt;
      eot_q       <= eot_nxt;
      err_sot_q   <= err_sot_nxt;
      err_ctrl_q  <= err_ctrl_nxt;
      err_to_q    <= err_to_nxt;
    end
  end

  // Next-state logic: LP-11 always has priority over enable, sync and timeouts.
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    burst_cnt_nxt = burst_cnt_q;
    sot_nxt       = 1'b0;
    eot_nxt       = 1'b0;
    err_sot_nxt   = 1'b0;
    err_ctrl_nxt  = 1'b0;
    err_to_nxt    = 1'b0;

    case (state_q)
      ST_STOP: begin
        cnt_nxt = '0;
        if (bus.enable) begin
          if (lp_s2_q == LP_01) begin
            state_nxt = ST_HS_RQST;
          end else if (lp_s2_q != LP_11) begin
            // Escape-mode and ULPS entry are not supported on this lane.
            state_nxt    = ST_ERR;
            err_ctrl_nxt = 1'b1;
          end
        end
      end

      ST_HS_RQST: begin
        cnt_nxt = '0;
        if (!bus.enable) begin
          state_nxt = ST_STOP;
        end else begin
          case (lp_s2_q)
            LP_00:   state_nxt = ST_SETTLE;
            LP_11:   state_nxt = ST_STOP;
            LP_10: begin
              state_nxt    = ST_ERR;
              err_ctrl_nxt = 1'b1;
            end
            default: state_nxt = ST_HS_RQST;
          endcase
        end
      end

      ST_SETTLE: begin
        if (lp_s2_q == LP_11) begin
          state_nxt    = ST_STOP;
          err_ctrl_nxt = 1'b1;
          cnt_nxt      = '0;
        end else if (!bus.enable) begin
          state_nxt = ST_STOP;
          cnt_nxt   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_nxt = ST_SYNC;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end

      ST_SYNC: begin
        if (lp_s2_q == LP_11) begin
          state_nxt    = ST_STOP;
          err_ctrl_nxt = 1'b1;
          cnt_nxt      = '0;
        end else if (!bus.enable) begin
          state_nxt = ST_STOP;
          cnt_nxt   = '0;
        end else if (bus.sync_found) begin
          state_nxt = ST_HS;
          sot_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else if (cnt_q == SYNC_LAST) begin
          state_nxt   = ST_ERR;
          err_sot_nxt = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end

      ST_HS: begin
        // Enable is deliberately not checked: a started burst always completes.
        if (lp_s2_q == LP_11) begin
          state_nxt     = ST_STOP;
          eot_nxt       = 1'b1;
          burst_cnt_nxt = burst_cnt_q + 16'd1;
          cnt_nxt       = '0;
        end else if (cnt_q == HS_LAST) begin
          state_nxt  = ST_ERR;
          err_to_nxt = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end

      ST_ERR: begin
        cnt_nxt = '0;
        if (lp_s2_q == LP_11) begin
          state_nxt = ST_STOP;
        end
      end

      default: begin
        state_nxt = ST_STOP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state so enables register on the transition edge.
  always_comb begin
    term_nxt   = 1'b0;
    rx_nxt     = 1'b0;
    search_nxt = 1'b0;
    active_nxt = 1'b0;
    case (state_nxt)
      ST_SETTLE: begin
        term_nxt = 1'b1;
        rx_nxt   = 1'b1;
      end
      ST_SYNC: begin
        term_nxt   = 1'b1;
        rx_nxt     = 1'b1;
        search_nxt = 1'b1;
      end
      ST_HS: begin
        term_nxt   = 1'b1;
        rx_nxt     = 1'b1;
        active_nxt = 1'b1;
      end
      default: begin
        term_nxt   = 1'b0;
        rx_nxt     = 1'b0;
        search_nxt = 1'b0;
        active_nxt = 1'b0;
      end
    endcase
  end

  assign bus.lane_term_en = term_q;
  assign bus.hs_rx_en     = rx_q;
  assign bus.sync_search  = search_q;
  assign bus.hs_active    = active_q;
  assign bus.sot_pulse    = sot_q;
  assign bus.eot_pulse    = eot_q;
  assign bus.err_sot      = err_sot_q;
  assign bus.err_ctrl     = err_ctrl_q;
  assign bus.err_timeout  = err_to_q;
  assign bus.lp_state     = lp_s2_q;
  assign bus.burst_count  = burst_cnt_q;

endmodule

// File: tb/tb_mipi_lane_hs_ctrl.sv
// Scoreboard bench for the lane HS sequencer. dut_a uses the default
// timeouts; dut_b has a 16-cycle HS timeout and is enabled only for that case.
module tb_mipi_lane_hs_ctrl;

  logic phy_clk = 1'b0;
  logic resetb  = 1'b0;
  logic dp = 1'b0, dn = 1'b0, sync_f = 1'b0;
  logic enable_a = 1'b0, enable_b = 1'b0;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  initial forever #5 phy_clk = ~phy_clk;
  always @(posedge phy_clk) cyc <= cyc + 1;

  mipi_lane_hs_ctrl_if bus_a ();
  mipi_lane_hs_ctrl_if bus_b ();

  assign bus_a.enable     = enable_a;
  assign bus_a.mdp_lp     = dp;
  assign bus_a.mdn_lp     = dn;
  assign bus_a.sync_found = sync_f;
  assign bus_b.enable     = enable_b;
  assign bus_b.mdp_lp     = dp;
  assign bus_b.mdn_lp     = dn;
  assign bus_b.sync_found = sync_f;

  mipi_lane_hs_ctrl #(.T_SETTLE_CYC(12), .SYNC_TIMEOUT_CYC(64), .HS_TIMEOUT_CYC(65535)) dut_a (
    .phy_clk(phy_clk), .resetb(resetb), .bus(bus_a));
  mipi_lane_hs_ctrl #(.T_SETTLE_CYC(12), .SYNC_TIMEOUT_CYC(64), .HS_TIMEOUT_CYC(16)) dut_b (
    .phy_clk(phy_clk), .resetb(resetb), .bus(bus_b));

  wire [8:0] outs_a = {bus_a.lane_term_en, bus_a.hs_rx_en, bus_a.sync_search, bus_a.hs_active,
                       bus_a.sot_pulse, bus_a.eot_pulse, bus_a.err_sot, bus_a.err_ctrl, bus_a.err_timeout};

  // Event codes: 0 term rise, 1 search rise, 2 hs_active rise, 3 sot, 4 eot,
  // 5 err_sot, 6 err_ctrl, 7 err_timeout.
  localparam int EV_TERM = 0, EV_SRCH = 1, EV_HSR = 2, EV_SOT = 3, EV_EOT = 4,
                 EV_ESOT = 5, EV_ECTL = 6, EV_ETO = 7;
  string ev_name [8] = '{"term_rise", "search_rise", "hs_rise", "sot", "eot",
                         "err_sot", "err_ctrl", "err_timeout"};

  typedef struct { int dut; int ev; int cyc; int bcnt; } exp_t;
  exp_t sbq [$];
  logic [2:0] prev_lvl [2];

  task automatic push(input int d, input int e, input int c, input int b);
    exp_t x;
    x.dut = d; x.ev = e; x.cyc = c; x.bcnt = b;
    sbq.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge phy_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive 11 -> 01 -> 00 on the pins; returns the cycle at which 00 was applied.
  task automatic sot_entry(output int c00);
    dp = 1'b0; dn = 1'b1;
    tick(4);
    dp = 1'b0; dn = 1'b0;
    c00 = cyc;
  endtask

  // Monitor: every edge or pulse on either DUT pops the scoreboard.
  always @(negedge phy_clk) begin
    logic [2:0]  lvl [2];
    logic [4:0]  pul [2];
    logic [15:0] bc  [2];
    logic [7:0]  ev;
    exp_t        x;
    lvl[0] = {bus_a.hs_active, bus_a.sync_search, bus_a.lane_term_en};
    lvl[1] = {bus_b.hs_active, bus_b.sync_search, bus_b.lane_term_en};
    pul[0] = {bus_a.err_timeout, bus_a.err_ctrl, bus_a.err_sot, bus_a.eot_pulse, bus_a.sot_pulse};
    pul[1] = {bus_b.err_timeout, bus_b.err_ctrl, bus_b.err_sot, bus_b.eot_pulse, bus_b.sot_pulse};
    bc[0]  = bus_a.burst_count;
    bc[1]  = bus_b.burst_count;
    for (int d = 0; d < 2; d++) begin
      ev = {pul[d], lvl[d] & ~prev_lvl[d]};
      for (int e = 0; e < 8; e++) begin
        if (ev[e]) begin
          n_tests++;
          if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: dut%0d %s at cycle %0d, required no event", d, ev_name[e], cyc);
          end else begin
            x = sbq.pop_front();
            if (x.dut != d || x.ev != e || x.cyc != cyc || (x.bcnt >= 0 && x.bcnt != int'(bc[d]))) begin
              n_fail++;
              $display("FAIL event: got dut%0d %s cycle %0d count %0d, required dut%0d %s cycle %0d count %0d",
                       d, ev_name[e], cyc, bc[d], x.dut, ev_name[x.ev], x.cyc, x.bcnt);
            end
          end
          if (e >= EV_EOT) begin
            n_tests++;
            if (lvl[d] != 3'b000) begin
              n_fail++;
              $display("FAIL enables_off: dut%0d after %s enables %b, required 000", d, ev_name[e], lvl[d]);
            end
          end
        end
      end
      prev_lvl[d] <= lvl[d];
    end
  end

  initial begin
    int c1, c2;
    prev_lvl[0] = 3'b000;
    prev_lvl[1] = 3'b000;

    // Reset hold with pins at LP-00.
    tick(4);
    chk("reset_outs", int'(outs_a), 0);
    chk("reset_lp_state", int'(bus_a.lp_state), 3);
    chk("reset_burst_count", int'(bus_a.burst_count), 0);
    resetb = 1'b1;
    tick(1);
    chk("sync_lat_1edge", int'(bus_a.lp_state), 3);
    tick(1);
    chk("sync_lat_2edge", int'(bus_a.lp_state), 0);
    chk("stop_disabled_outs", int'(outs_a), 0);
    dp = 1'b1; dn = 1'b1;
    tick(2);
    chk("lp_back_to_11", int'(bus_a.lp_state), 3);

    // Normal burst, with a stray sync_found during settle that must be ignored.
    enable_a = 1'b1;
    tick(2);
    sot_entry(c1);
    push(0, EV_TERM, c1 + 3, -1);
    push(0, EV_SRCH, c1 + 15, -1);
    push(0, EV_HSR, c1 + 20, -1);
    push(0, EV_SOT, c1 + 20, -1);
    tick(8);
    sync_f = 1'b1; tick(1); sync_f = 1'b0;
    tick(7);
    chk("sync_levels", int'(outs_a[8:5]), 4'b1110);
    tick(3);
    sync_f = 1'b1; tick(1); sync_f = 1'b0;
    tick(1);
    chk("hs_levels", int'(outs_a[8:5]), 4'b1101);
    sync_f = 1'b1; tick(1); sync_f = 1'b0;
    tick(97);
    dp = 1'b1; dn = 1'b1;
    c2 = cyc;
    push(0, EV_EOT, c2 + 3, 1);
    tick(6);
    chk("burst_count_1", int'(bus_a.burst_count), 1);

    // Sync timeout, then park in ST_ERR until LP-11.
    sot_entry(c1);
    push(0, EV_TERM, c1 + 3, -1);
    push(0, EV_SRCH, c1 + 15, -1);
    push(0, EV_ESOT, c1 + 79, 1);
    tick(100);
    dp = 1'b1; dn = 1'b0;
    tick(10);
    chk("err_parked_outs", int'(outs_a), 0);
    dp = 1'b1; dn = 1'b1;
    tick(5);

    // Illegal 01 -> 10, recover via LP-11, then a valid burst.
    dp = 1'b0; dn = 1'b1;
    tick(4);
    dp = 1'b1; dn = 1'b0;
    push(0, EV_ECTL, cyc + 3, 1);
    tick(5);
    dp = 1'b1; dn = 1'b1;
    tick(5);
    sot_entry(c1);
    push(0, EV_TERM, c1 + 3, -1);
    push(0, EV_SRCH, c1 + 15, -1);
    push(0, EV_HSR, c1 + 17, -1);
    push(0, EV_SOT, c1 + 17, -1);
    tick(16);
    sync_f = 1'b1; tick(1); sync_f = 1'b0;
    tick(10);
    dp = 1'b1; dn = 1'b1;
    push(0, EV_EOT, cyc + 3, 2);
    tick(6);
    chk("burst_count_2", int'(bus_a.burst_count), 2);

    // LP-11 during settle.
    sot_entry(c1);
    push(0, EV_TERM, c1 + 3, -1);
    push(0, EV_ECTL, c1 + 9, 2);
    tick(6);
    dp = 1'b1; dn = 1'b1;
    tick(6);

    // LP-11 coincident with sync_found in ST_SYNC: LP-11 wins.
    sot_entry(c1);
    push(0, EV_TERM, c1 + 3, -1);
    push(0, EV_SRCH, c1 + 15, -1);
    push(0, EV_ECTL, c1 + 23, 2);
    tick(20);
    dp = 1'b1; dn = 1'b1;
    tick(2);
    sync_f = 1'b1; tick(1); sync_f = 1'b0;
    tick(5);

    // Enable dropped in ST_HS_RQST: silent return to ST_STOP, then stays off.
    dp = 1'b0; dn = 1'b1;
    tick(4);
    enable_a = 1'b0;
    tick(3);
    dp = 1'b0; dn = 1'b0;
    tick(20);
    chk("disabled_outs", int'(outs_a), 0);
    dp = 1'b1; dn = 1'b1;
    tick(5);

    // HS timeout on dut_b with pins held at LP-00.
    enable_b = 1'b1;
    tick(2);
    sot_entry(c1);
    push(1, EV_TERM, c1 + 3, -1);
    push(1, EV_SRCH, c1 + 15, -1);
    push(1, EV_HSR, c1 + 17, -1);
    push(1, EV_SOT, c1 + 17, -1);
    push(1, EV_ETO, c1 + 33, 0);
    tick(16);
    sync_f = 1'b1; tick(1); sync_f = 1'b0;
    tick(23);
    dp = 1'b1; dn = 1'b1;
    tick(6);
    enable_b = 1'b0;
    chk("b_burst_count_0", int'(bus_b.burst_count), 0);

    // Wrap from FFFF, with enable dropped mid-burst.
    force dut_a.burst_cnt_q = 16'hFFFF;
    tick(1);
    release dut_a.burst_cnt_q;
    tick(1);
    chk("preload_ffff", int'(bus_a.burst_count), 16'hFFFF);
    enable_a = 1'b1;
    tick(2);
    sot_entry(c1);
    push(0, EV_TERM, c1 + 3, -1);
    push(0, EV_SRCH, c1 + 15, -1);
    push(0, EV_HSR, c1 + 17, -1);
    push(0, EV_SOT, c1 + 17, -1);
    tick(16);
    sync_f = 1'b1; tick(1); sync_f = 1'b0;
    tick(8);
    enable_a = 1'b0;
    tick(10);
    chk("hs_survives_enable_drop", int'(bus_a.hs_active), 1);
    dp = 1'b1; dn = 1'b1;
    push(0, EV_EOT, cyc + 3, 0);
    tick(6);
    chk("burst_count_wrap", int'(bus_a.burst_count), 0);

    // Reset mid-burst: hs_active drops on the reset edge, no eot.
    enable_a = 1'b1;
    tick(2);
    sot_entry(c1);
    push(0, EV_TERM, c1 + 3, -1);
    push(0, EV_SRCH, c1 + 15, -1);
    push(0, EV_HSR, c1 + 17, -1);
    push(0, EV_SOT, c1 + 17, -1);
    tick(16);
    sync_f = 1'b1; tick(1); sync_f = 1'b0;
    tick(5);
    resetb = 1'b0;
    tick(1);
    chk("reset_mid_burst_outs", int'(outs_a), 0);
    dp = 1'b1; dn = 1'b1;
    tick(2);
    resetb = 1'b1;
    tick(5);
    chk("reset_mid_burst_lp", int'(bus_a.lp_state), 3);

    while (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_event: got none, required dut%0d %s at cycle %0d", x.dut, ev_name[x.ev], x.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
